// File: rtl/spi_display_master.sv
// spi_display_master
// SPI master that serialises 16-bit register-write frames {CMD, addr, data},
// MSB first, for the Nexys4 display SPI slave. One write per valid/ready handshake.
// SCLK, SS and MOSI idle high; the slave samples MOSI on SCLK rising while SS is low.
//
// Ports:
//   block_clk_i   block clock, all logic on its rising edge
//   rst_high_i    synchronous active-high reset
//   wr_valid_i    write request valid
//   wr_ready_o    request can be accepted (IDLE only)
//   wr_addr_i     target register (0 enable, 1-8 digits, 9 radix)
//   wr_data_i     register value
//   busy_o        state is not IDLE
//   frame_done_o  one-cycle pulse on GAP->IDLE
//   spi_sclk_o    SPI clock
//   spi_ss_o      slave select, active low
//   spi_mosi_o    serial data
module spi_display_master #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8,
   parameter logic [3:0]  CMD        = 4'b0001
) (
   input  logic       block_clk_i,
   input  logic       rst_high_i,
   input  logic       wr_valid_i,
   output logic       wr_ready_o,
   input  logic [3:0] wr_addr_i,
   input  logic [7:0] wr_data_i,
   output logic       busy_o,
   output logic       frame_done_o,
   output logic       spi_sclk_o,
   output logic       spi_ss_o,
   output logic       spi_mosi_o
);

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int unsigned HC_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(CLK_DIV - 1);
   localparam logic [HC_W-1:0]  GAP_LAST  = HC_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_LOW,
      ST_HIGH,
      ST_POST,
      ST_REL,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [HC_W-1:0]      hc_q, hc_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 ss_q, ss_d;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 half_last;

   // State register and registered outputs
   always_ff @(posedge block_clk_i) begin
      if (rst_high_i) begin
         state_q   <= ST_REL;
         hc_q      <= '0;
         bit_idx_q <= IDX_MSB;
         frame_q   <= '0;
         ss_q      <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         bit_idx_q <= bit_idx_d;
         frame_q   <= frame_d;
         ss_q      <= ss_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state, counter and next-output logic
   always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      ss_d      = ss_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      half_last = (hc_q == HALF_LAST);

      case (state_q)
         ST_IDLE: begin
            if (wr_valid_i && ready_q) begin
               frame_d   = {CMD, wr_addr_i, wr_data_i};
               bit_idx_d = IDX_MSB;
               state_d   = ST_PRE;
            end
         end
         ST_PRE: begin
            if (half_last) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (half_last) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (half_last) begin
               if (bit_idx_q == '0) begin
                  state_d = ST_POST;
               end else begin
                  bit_idx_d = bit_idx_q - IDX_W'(1);
                  state_d   = ST_LOW;
               end
            end
         end
         ST_POST: begin
            if (half_last) state_d = ST_REL;
         end
         ST_REL: begin
            if (half_last) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (hc_q == GAP_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Phase timer restarts on every state change; IDLE does not count
      if (state_d != state_q) begin
         hc_d = '0;
      end else if (state_q != ST_IDLE) begin
         hc_d = hc_q + HC_W'(1);
      end

      // Outputs change only on state entry; each transition moves either SS or SCLK, never both
      if (state_d != state_q) begin
         ready_d = 1'b0;
         busy_d  = 1'b1;
         case (state_d)
            ST_IDLE: begin
               ss_d    = 1'b1;
               sclk_d  = 1'b1;
               mosi_d  = 1'b1;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
            ST_PRE: begin
               ss_d   = 1'b1;
               sclk_d = 1'b0;
               mosi_d = 1'b1;
            end
            ST_LOW: begin
               ss_d   = 1'b0;
               sclk_d = 1'b0;
               mosi_d = frame_d[bit_idx_d];
            end
            ST_HIGH: begin
               ss_d   = 1'b0;
               sclk_d = 1'b1;
            end
            ST_POST: begin
               ss_d   = 1'b0;
               sclk_d = 1'b0;
            end
            ST_REL: begin
               ss_d   = 1'b1;
               sclk_d = 1'b0;
               mosi_d = 1'b1;
            end
            ST_GAP: begin
               ss_d   = 1'b1;
               sclk_d = 1'b1;
               mosi_d = 1'b1;
            end
            default: begin
               ss_d   = 1'b1;
               sclk_d = 1'b1;
            end
         endcase
      end
   end

   assign wr_ready_o   = ready_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;
   assign spi_sclk_o   = sclk_q;
   assign spi_ss_o     = ss_q;
   assign spi_mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_display_master.sv
// Bench for spi_display_master: two instances (default timing and CLK_DIV=2/GAP=4),
// random writes, a behavioural display-slave model and a queue-based scoreboard.
module tb_spi_display_master;

   localparam int unsigned CD0 = 4;
   localparam int unsigned GP0 = 8;
   localparam int unsigned CD1 = 2;
   localparam int unsigned GP1 = 4;
   localparam int          TMO = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  [2];
   logic       vld  [2];
   logic [3:0] adr  [2];
   logic [7:0] dat  [2];
   logic       rdy  [2];
   logic       bsy  [2];
   logic       dne  [2];
   logic       sclk [2];
   logic       ss   [2];
   logic       mosi [2];

   spi_display_master #(.CLK_DIV(CD0), .GAP_CYCLES(GP0), .CMD(4'b0001)) u_dut0 (
      .block_clk_i(clk), .rst_high_i(rst[0]), .wr_valid_i(vld[0]), .wr_ready_o(rdy[0]),
      .wr_addr_i(adr[0]), .wr_data_i(dat[0]), .busy_o(bsy[0]), .frame_done_o(dne[0]),
      .spi_sclk_o(sclk[0]), .spi_ss_o(ss[0]), .spi_mosi_o(mosi[0]));

   spi_display_master #(.CLK_DIV(CD1), .GAP_CYCLES(GP1), .CMD(4'b0001)) u_dut1 (
      .block_clk_i(clk), .rst_high_i(rst[1]), .wr_valid_i(vld[1]), .wr_ready_o(rdy[1]),
      .wr_addr_i(adr[1]), .wr_data_i(dat[1]), .busy_o(bsy[1]), .frame_done_o(dne[1]),
      .spi_sclk_o(sclk[1]), .spi_ss_o(ss[1]), .spi_mosi_o(mosi[1]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Scoreboard queues: expected frames and accept cycles, per instance
   int unsigned exp_f0[$];
   int unsigned exp_f1[$];
   int          exp_a0[$];
   int          exp_a1[$];

   // Slave model registers and the bench's expected register file
   logic [7:0] sreg [2][10];
   logic [7:0] mreg [2][10];

   // Monitor state
   logic        p_ss [2];
   logic        p_sclk [2];
   logic        p_mosi [2];
   logic [15:0] shr [2];
   int          nb [2];
   int          stab [2];
   int          run [2];
   int          last_rise [2];
   bit          seen [2];
   bit          allow_done [2];

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got 0x%0h want 0x%0h (cycle %0d)", name, i, act, exp, cyc);
      end
   endtask

   function automatic int cdiv(input int i);
      return (i == 0) ? CD0 : CD1;
   endfunction

   function automatic int gapc(input int i);
      return (i == 0) ? GP0 : GP1;
   endfunction

   // Accept-to-IDLE: PRE + 16*(LOW+HIGH) + POST + REL half-periods, then the gap
   function automatic int lat(input int i);
      return cdiv(i) * (1 + 32 + 1 + 1) + gapc(i);
   endfunction

   function automatic int pending(input int i);
      return (i == 0) ? (exp_f0.size() + exp_a0.size()) : (exp_f1.size() + exp_a1.size());
   endfunction

   // Monitor + slave model, one instance per call, sampled 1ns after the clock edge
   task automatic mon(input int i);
      logic [15:0] s;
      int unsigned ef;
      int          ea;
      if (rst[i]) begin
         check("rst_ss", i, 32'(ss[i]), 32'd1);
         check("rst_sclk", i, 32'(sclk[i]), 32'd0);
         check("rst_mosi", i, 32'(mosi[i]), 32'd1);
         check("rst_ready", i, 32'(rdy[i]), 32'd0);
         check("rst_busy", i, 32'(bsy[i]), 32'd1);
         check("rst_no_done", i, 32'(dne[i]), 32'd0);
         nb[i] = 0; shr[i] = '0; seen[i] = 1'b0; allow_done[i] = 1'b1; run[i] = 0; stab[i] = 0;
         if (i == 0) begin exp_f0.delete(); exp_a0.delete(); end
         else begin exp_f1.delete(); exp_a1.delete(); end
      end else begin
         check("ready_vs_busy", i, 32'(rdy[i]), 32'(!bsy[i]));
         if (ss[i] !== p_ss[i] || sclk[i] !== p_sclk[i])
            check("ss_sclk_same_edge", i, 32'((ss[i] !== p_ss[i]) && (sclk[i] !== p_sclk[i])), 32'd0);
         if (mosi[i] !== p_mosi[i]) stab[i] = 0;
         else stab[i]++;
         if (p_ss[i] && !ss[i]) begin
            nb[i] = 0; shr[i] = '0;
         end
         if (!ss[i] && sclk[i] && !p_sclk[i]) begin
            check("mosi_setup", i, 32'(stab[i] >= cdiv(i)), 32'd1);
            if (nb[i] > 0) check("sclk_period", i, 32'(cyc - last_rise[i]), 32'(2 * cdiv(i)));
            last_rise[i] = cyc;
            s = shr[i];
            shr[i] = {s[14:0], mosi[i]};
            nb[i]++;
         end
         if (!p_ss[i] && ss[i]) begin
            s = shr[i];
            check("bits_per_frame", i, 32'(nb[i]), 32'd16);
            if (nb[i] == 16 && s[15:12] == 4'h1 && s[11:8] <= 4'd9)
               sreg[i][s[11:8]] = s[7:0];
            if (((i == 0) ? exp_f0.size() : exp_f1.size()) == 0) begin
               check("frame_pending", i, 32'd0, 32'd1);
            end else begin
               ef = (i == 0) ? exp_f0.pop_front() : exp_f1.pop_front();
               check("frame", i, {16'h0, s}, ef);
            end
            seen[i] = 1'b1;
         end
         if (ss[i] && sclk[i]) begin
            run[i]++;
         end else begin
            if (ss[i] && !sclk[i] && p_ss[i] && p_sclk[i] && seen[i])
               check("gap_len", i, 32'(run[i] >= gapc(i)), 32'd1);
            run[i] = 0;
         end
         if (dne[i]) begin
            if (((i == 0) ? exp_a0.size() : exp_a1.size()) != 0) begin
               ea = (i == 0) ? exp_a0.pop_front() : exp_a1.pop_front();
               check("done_latency", i, 32'(cyc - ea), 32'(lat(i)));
            end else if (allow_done[i]) begin
               allow_done[i] = 1'b0;
            end else begin
               check("done_unexpected", i, 32'd1, 32'd0);
            end
         end
      end
      p_ss[i] = ss[i]; p_sclk[i] = sclk[i]; p_mosi[i] = mosi[i];
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) mon(i);
   end

   // Drive one request from a negedge; returns on the negedge after the accepting edge
   task automatic send(input int i, input logic [3:0] a, input logic [7:0] d, input bit commit,
                       output int acc_o);
      int t;
      int unsigned fr;
      t = 0;
      vld[i] = 1'b1; adr[i] = a; dat[i] = d;
      while (rdy[i] !== 1'b1 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      acc_o = -1;
      if (t >= TMO) begin
         check("accept_timeout", i, 32'd0, 32'd1);
      end else begin
         @(negedge clk);
         acc_o = cyc;
         fr = 4096 * 1 + 256 * int'(a) + int'(d);
         if (i == 0) begin exp_f0.push_back(fr); exp_a0.push_back(acc_o); end
         else begin exp_f1.push_back(fr); exp_a1.push_back(acc_o); end
         if (commit && a <= 4'd9) mreg[i][a] = d;
      end
   endtask

   task automatic wait_drain(input int i);
      int t;
      t = 0;
      while ((pending(i) != 0 || rdy[i] !== 1'b1) && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (t >= TMO) check("drain_timeout", i, 32'(pending(i)), 32'd0);
   endtask

   task automatic random_writes(input int i, input int n);
      int acc;
      int g;
      for (int k = 0; k < n; k++) begin
         send(i, 4'($urandom_range(0, 11)), 8'($urandom), 1'b1, acc);
         g = $urandom_range(0, 3);
         if (g != 0) begin
            vld[i] = 1'b0;
            repeat (g) @(negedge clk);
         end
      end
      vld[i] = 1'b0;
      wait_drain(i);
   endtask

   task automatic display_pattern(input int i);
      int acc;
      send(i, 4'd0, 8'hFF, 1'b1, acc);
      for (int k = 1; k <= 8; k++) send(i, 4'(k), 8'(k), 1'b1, acc);
      send(i, 4'd9, 8'h01, 1'b1, acc);
      vld[i] = 1'b0;
      wait_drain(i);
      check("slave_enable", i, 32'(sreg[i][0]), 32'hFF);
      check("slave_radix", i, 32'(sreg[i][9]), 32'h01);
      for (int k = 1; k <= 8; k++) check("slave_digit", i, 32'(sreg[i][k]), 32'(k));
   endtask

   initial begin
      int first_sclk [2];
      int first_rdy [2];
      int a1;
      int a2;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; vld[i] = 1'b0; adr[i] = '0; dat[i] = '0;
         p_ss[i] = 1'b1; p_sclk[i] = 1'b0; p_mosi[i] = 1'b1;
         shr[i] = '0; nb[i] = 0; stab[i] = 0; run[i] = 0; last_rise[i] = 0;
         seen[i] = 1'b0; allow_done[i] = 1'b1;
         first_sclk[i] = -1; first_rdy[i] = -1;
         for (int k = 0; k < 10; k++) begin sreg[i][k] = '0; mreg[i][k] = '0; end
      end
      repeat (2) @(negedge clk);

      // Release: SCLK stays low for one half-period, ready after the gap
      rst[0] = 1'b0; rst[1] = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (sclk[i] === 1'b1 && first_sclk[i] < 0) first_sclk[i] = k;
            if (rdy[i] === 1'b1 && first_rdy[i] < 0) first_rdy[i] = k;
         end
      end
      for (int i = 0; i < 2; i++) begin
         check("release_sclk_high", i, 32'(first_sclk[i]), 32'(cdiv(i)));
         check("release_ready", i, 32'(first_rdy[i]), 32'(cdiv(i) + gapc(i)));
      end

      // Single frame 0x13A5
      send(0, 4'd3, 8'hA5, 1'b1, a1);
      vld[0] = 1'b0;
      wait_drain(0);

      // Valid held high across two frames: accepted on the first IDLE cycle
      send(0, 4'd1, 8'h0F, 1'b1, a1);
      send(0, 4'd9, 8'h80, 1'b1, a2);
      vld[0] = 1'b0;
      check("b2b_spacing", 0, 32'(a2 - a1), 32'(lat(0) + 1));
      wait_drain(0);

      // Reset during bit 7 of a frame
      send(0, 4'd5, 8'h3C, 1'b0, a1);
      vld[0] = 1'b0;
      repeat (70) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      wait_drain(0);
      check("abort_no_write", 0, 32'(sreg[0][5]), 32'(mreg[0][5]));

      random_writes(0, 10);
      display_pattern(0);
      for (int k = 0; k < 10; k++) check("readback", 0, 32'(sreg[0][k]), 32'(mreg[0][k]));

      // Fast timing instance
      send(1, 4'd3, 8'hA5, 1'b1, a1);
      send(1, 4'd2, 8'h5A, 1'b1, a2);
      vld[1] = 1'b0;
      check("b2b_spacing", 1, 32'(a2 - a1), 32'(lat(1) + 1));
      wait_drain(1);
      random_writes(1, 8);
      display_pattern(1);
      for (int k = 0; k < 10; k++) check("readback", 1, 32'(sreg[1][k]), 32'(mreg[1][k]));

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
